adsr_env: RTL and testbench

- Gated, parametrised ADSR envelope generator and amplitude modulator for the synth voice path.
- Sits between the oscillator/mixer output and the codec sample stream; operates on the codec's 48 kHz in_ready strobe.
- Unlike the fixed free-running envelope, it is note-driven: gate on/off, retrigger, runtime-programmable rates and sustain level.
- It produces a true multiply-based linear envelope at ENV_W resolution, replacing shift-add approximations.

---
 rtl/adsr_env.sv | 162 ++++++++++++++++
 tb/tb_adsr_env.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_env.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_env
//  Purpose  : Note-driven ADSR envelope generator and amplitude modulator.
//             Advances the envelope once every RATE_DIV sample strobes and
//             scales each incoming sample by the current envelope level.
//  Revision : 1.0  initial release
// ============================================================================
module adsr_env #(
    parameter int WIDTH    = 16,
    parameter int ENV_W    = 8,
    parameter int RATE_DIV = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_ready,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] decay_step,
    input  logic [ENV_W-1:0] sustain_level,
    input  logic [ENV_W-1:0] release_step,
    output logic [WIDTH-1:0] sample_out,
    output logic             out_valid,
    output logic [ENV_W-1:0] level,
    output logic [2:0]       state,
    output logic             busy
);

    localparam int               c_pre_w     = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(RATE_DIV - 1);
    localparam logic [ENV_W-1:0]  c_level_max = '1;
    localparam int               c_prod_w    = WIDTH + ENV_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                     r_state;
    logic [c_pre_w-1:0]         r_prescaler;
    logic                       r_gate_d;

    logic                       w_rise;
    logic                       w_fall;
    logic                       w_tick;
    logic                       w_gate_off_ok;
    logic [ENV_W:0]             w_attack_sum;
    logic signed [ENV_W:0]      w_decay_diff;
    logic                       w_decay_hits_sustain;
    logic                       w_release_done;
    logic signed [c_prod_w-1:0] w_sample_ext;
    logic signed [c_prod_w-1:0] w_level_ext;
    logic signed [c_prod_w-1:0] w_product;
    logic                       w_unused_product_bits;

    assign w_rise = gate & ~r_gate_d;
    assign w_fall = ~gate & r_gate_d;
    assign w_tick = in_ready & (r_prescaler == c_pre_last);

    // A gate fall only matters while the key-held phases are active.
    assign w_gate_off_ok = (r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                           (r_state == ST_SUSTAIN);

    // One extra bit so attack can saturate and decay can go below zero.
    assign w_attack_sum         = {1'b0, level} + {1'b0, attack_step};
    assign w_decay_diff         = $signed({1'b0, level}) - $signed({1'b0, decay_step});
    assign w_decay_hits_sustain = (w_decay_diff <= $signed({1'b0, sustain_level}));
    assign w_release_done       = (release_step >= level);

    // Level is zero-extended so it always acts as a non-negative gain.
    assign w_sample_ext = c_prod_w'($signed(sample_in));
    assign w_level_ext  = c_prod_w'($signed({1'b0, level}));
    assign w_product    = w_sample_ext * w_level_ext;

    // Fraction bits and the redundant sign bit are dropped by the shift.
    assign w_unused_product_bits = ^{w_product[ENV_W-1:0], w_product[c_prod_w-1]};

    assign state = r_state;
    assign busy  = (r_state != ST_IDLE);

    // Gate edge history and envelope-rate prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gate_d    <= 1'b0;
            r_prescaler <= '0;
        end else begin
            r_gate_d <= gate;
            if (in_ready) begin
                r_prescaler <= w_tick ? '0 : r_prescaler + c_pre_w'(1);
            end
        end
    end

    // Envelope state machine: gate edges win over ticks and suppress the step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            level   <= '0;
        end else if (w_rise) begin
            r_state <= ST_ATTACK;
        end else if (w_fall && w_gate_off_ok) begin
            r_state <= ST_RELEASE;
        end else if (r_state == ST_IDLE) begin
            level <= '0;
        end else if (w_tick) begin
            case (r_state)
                ST_ATTACK: begin
                    if (attack_step != '0) begin
                        if (w_attack_sum >= {1'b0, c_level_max}) begin
                            level   <= c_level_max;
                            r_state <= ST_DECAY;
                        end else begin
                            level <= w_attack_sum[ENV_W-1:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (w_decay_hits_sustain) begin
                        level   <= sustain_level;
                        r_state <= ST_SUSTAIN;
                    end else begin
                        level <= w_decay_diff[ENV_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    level <= sustain_level;
                end
                ST_RELEASE: begin
                    if (w_release_done) begin
                        level   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        level <= level - release_step;
                    end
                end
                default: begin
                    level   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample scaling uses the level as registered before this cycle's update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_ready;
            if (in_ready) begin
                sample_out <= w_product[ENV_W +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adsr_env.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adsr_env
//  Purpose  : Self-checking bench for adsr_env: directed envelope walk-through
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adsr_env;

    localparam int WIDTH    = 16;
    localparam int ENV_W    = 8;
    localparam int RATE_DIV = 4;
    localparam int MAXL     = 255;

    localparam int IDL = 0;
    localparam int ATK = 1;
    localparam int DEC = 2;
    localparam int SUS = 3;
    localparam int REL = 4;

    logic             clk;
    logic             reset;
    logic             in_ready;
    logic [WIDTH-1:0] sample_in;
    logic             gate;
    logic [ENV_W-1:0] attack_step;
    logic [ENV_W-1:0] decay_step;
    logic [ENV_W-1:0] sustain_level;
    logic [ENV_W-1:0] release_step;
    logic [WIDTH-1:0] sample_out;
    logic             out_valid;
    logic [ENV_W-1:0] level;
    logic [2:0]       state;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // behavioural reference state
    int m_level, m_st, m_pre, m_out;
    bit m_gd, m_ov, m_ticked;

    adsr_env #(
        .WIDTH    (WIDTH),
        .ENV_W    (ENV_W),
        .RATE_DIV (RATE_DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_ready      (in_ready),
        .sample_in     (sample_in),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .sample_out    (sample_out),
        .out_valid     (out_valid),
        .level         (level),
        .state         (state),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // round toward minus infinity
    function automatic int floor_div256(input int p);
        int q;
        q = p / 256;
        if ((p < 0) && (q * 256 != p)) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] rnd_step();
        if ($urandom_range(0, 3) == 0) return 8'd0;
        return 8'($urandom_range(1, 255));
    endfunction

    task automatic model_reset();
        m_level = 0; m_st = IDL; m_pre = 0; m_out = 0;
        m_gd = 0; m_ov = 0; m_ticked = 0;
    endtask

    task automatic check_outputs();
        chk("level",      32'(level),              32'(m_level));
        chk("state",      32'(state),              32'(m_st));
        chk("busy",       32'(busy),               32'(m_st != IDL));
        chk("out_valid",  32'(out_valid),          32'(m_ov));
        chk("sample_out", 32'($signed(sample_out)), 32'(m_out));
    endtask

    // Advance one clock: predict from the envelope rules, then compare.
    task automatic cycle();
        bit rise, fall, tk;
        int nl, ns, np, no, a, d, s, r;
        bit nov;
        a = int'(attack_step); d = int'(decay_step);
        s = int'(sustain_level); r = int'(release_step);
        rise = gate && !m_gd;
        fall = !gate && m_gd;
        tk   = in_ready && (m_pre == RATE_DIV - 1);
        np   = in_ready ? (m_pre + 1) % RATE_DIV : m_pre;
        nl   = m_level;
        ns   = m_st;
        if (rise) ns = ATK;
        else if (fall && (m_st == ATK || m_st == DEC || m_st == SUS)) ns = REL;
        else if (m_st == IDL) nl = 0;
        else if (tk) begin
            if (m_st == ATK) begin
                if (a != 0) begin
                    nl = (m_level + a > MAXL) ? MAXL : m_level + a;
                    if (nl == MAXL) ns = DEC;
                end
            end else if (m_st == DEC) begin
                if (m_level - d <= s) begin nl = s; ns = SUS; end
                else nl = m_level - d;
            end else if (m_st == SUS) begin
                nl = s;
            end else if (m_st == REL) begin
                if (r >= m_level) begin nl = 0; ns = IDL; end
                else nl = m_level - r;
            end
        end
        nov = in_ready;
        no  = in_ready ? floor_div256(int'($signed(sample_in)) * m_level) : m_out;
        @(posedge clk);
        #1;
        m_level = nl; m_st = ns; m_pre = np; m_gd = gate;
        m_out = no; m_ov = nov; m_ticked = tk;
        check_outputs();
    endtask

    task automatic wait_tick();
        bit hit;
        hit = 0;
        for (int k = 0; k < 4 * RATE_DIV; k++) begin
            cycle();
            if (m_ticked) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            errors++;
            $error("FAIL tick_timeout: observed 0, expected 1");
        end
    endtask

    task automatic run_until_state(input int target, input int budget);
        bit hit;
        hit = (m_st == target);
        for (int k = 0; k < budget && !hit; k++) begin
            cycle();
            hit = (m_st == target);
        end
        if (!hit) begin
            errors++;
            $error("FAIL state_timeout: observed %0d, expected %0d", m_st, target);
        end
    endtask

    // Reset is pulsed between clock edges to show it acts without a clock.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_level",      32'(level),      32'd0);
        chk("rst_state",      32'(state),      32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_sample_out", 32'(sample_out), 32'd0);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        in_ready = 1'b1; sample_in = '0; gate = 1'b0;
        attack_step = 8'd64; decay_step = 8'd50;
        sustain_level = 8'd128; release_step = 8'd100;
        do_reset();

        // mid-stream reset while a note is sounding
        gate = 1'b1; sample_in = 16'd1000;
        for (int k = 0; k < 7; k++) cycle();
        do_reset();
        gate = 1'b0;
        cycle();

        // attack ramp to full scale
        gate = 1'b1;
        cycle();
        wait_tick(); chk("atk_lvl1", 32'(level), 32'd64);
        wait_tick(); chk("atk_lvl2", 32'(level), 32'd128);
        wait_tick(); chk("atk_lvl3", 32'(level), 32'd192);
        wait_tick(); chk("atk_lvl4", 32'(level), 32'd255);
        chk("atk_to_decay", 32'(state), 32'd2);
        sample_in = 16'd1000;
        cycle();
        chk("mul_full", 32'($signed(sample_out)), 32'd996);
        chk("mul_valid", 32'(out_valid), 32'd1);

        // decay into sustain, then runtime sustain change
        wait_tick(); chk("dec_lvl1", 32'(level), 32'd205);
        wait_tick(); chk("dec_lvl2", 32'(level), 32'd155);
        wait_tick(); chk("dec_lvl3", 32'(level), 32'd128);
        chk("dec_to_sus", 32'(state), 32'd3);
        sustain_level = 8'd100;
        wait_tick(); chk("sus_track", 32'(level), 32'd100);
        sustain_level = 8'd128;
        wait_tick(); chk("sus_back", 32'(level), 32'd128);

        // release with a negative sample
        gate = 1'b0;
        cycle();
        wait_tick(); chk("rel_lvl1", 32'(level), 32'd28);
        chk("rel_state", 32'(state), 32'd4);
        sample_in = 16'hFC18;  // -1000
        cycle();
        chk("mul_neg", 32'($signed(sample_out)), 32'hFFFF_FF92);  // -110
        wait_tick(); chk("rel_lvl0", 32'(level), 32'd0);
        chk("rel_idle", 32'(state), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        // retrigger coinciding with a release tick
        gate = 1'b1;
        cycle();
        run_until_state(SUS, 80);
        chk("re_sus_lvl", 32'(level), 32'd128);
        gate = 1'b0;
        cycle();
        wait_tick(); chk("re_rel_lvl", 32'(level), 32'd28);
        for (int k = 0; k < RATE_DIV && m_pre != RATE_DIV - 1; k++) cycle();
        gate = 1'b1;
        cycle();
        chk("retrig_state", 32'(state), 32'd1);
        chk("retrig_hold", 32'(level), 32'd28);
        wait_tick(); chk("retrig_step", 32'(level), 32'd92);

        // zero attack step holds, then a large step completes attack
        gate = 1'b0; release_step = 8'd255;
        cycle();
        run_until_state(IDL, 20);
        attack_step = 8'd0; gate = 1'b1;
        cycle();
        for (int k = 0; k < 10; k++) begin
            wait_tick();
            chk("hold_lvl", 32'(level), 32'd0);
            chk("hold_state", 32'(state), 32'd1);
        end
        attack_step = 8'd255;
        wait_tick();
        chk("hold_release_lvl", 32'(level), 32'd255);
        chk("hold_release_state", 32'(state), 32'd2);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_ready  = ($urandom_range(0, 9) < 7);
            sample_in = 16'($urandom);
            if ($urandom_range(0, 29) == 0) gate = ~gate;
            if ($urandom_range(0, 49) == 0) attack_step   = rnd_step();
            if ($urandom_range(0, 49) == 0) decay_step    = rnd_step();
            if ($urandom_range(0, 49) == 0) sustain_level = 8'($urandom);
            if ($urandom_range(0, 49) == 0) release_step  = rnd_step();
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
